hdb3_polar: RTL

- Final stage of the HDB3 encoder chain. It sits directly downstream of the B-code insertion stage.
- Consumes the 2-bit symbol stream: 00 = zero, 01 = mark, 11 = V, 10 = B. Assigns line polarity to each symbol and drives the bipolar line pair.
- Also monitors the stream for coding faults: V-polarity alternation and running DC disparity.

---
 rtl/hdb3_polar_pkg.sv | 24 ++
 rtl/hdb3_polar_disparity.sv | 50 +++++
 rtl/hdb3_polar.sv | 102 ++++++++++
 3 files changed

// File: rtl/hdb3_polar_pkg.sv
// Shared symbol/polarity codes and state encodings for the HDB3 polarity stage.
package hdb3_polar_pkg;

    // Symbol codes delivered by the B-insertion stage
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_B    = 2'b10;
    localparam logic [1:0] CODE_V    = 2'b11;

    // Line polarity codes
    localparam logic [1:0] POL_ZERO = 2'b00;
    localparam logic [1:0] POL_POS  = 2'b01;
    localparam logic [1:0] POL_NEG  = 2'b10;

    // Reset is active high
    localparam logic RST_ACTIVE = 1'b1;

    // Polarity of the most recent mark/B/V pulse on the line
    typedef enum logic {
        LAST_POS = 1'b0,
        LAST_NEG = 1'b1
    } pol_state_t;

endpackage

// File: rtl/hdb3_polar_disparity.sv
// Saturating signed running-disparity accumulator with sticky limit flag.
module hdb3_polar_disparity
    import hdb3_polar_pkg::*;
#(
    parameter int unsigned DISP_W     = 6,
    parameter int unsigned DISP_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pulse_en,
    input  logic                     pulse_neg,
    output logic signed [DISP_W-1:0] disparity,
    output logic                     disp_err
);

    localparam logic signed [DISP_W-1:0] DISP_MAX = {1'b0, {(DISP_W-1){1'b1}}};
    localparam logic signed [DISP_W-1:0] DISP_MIN = {1'b1, {(DISP_W-1){1'b0}}};
    localparam logic signed [DISP_W-1:0] LIM_POS  = DISP_W'(DISP_LIMIT);
    localparam logic signed [DISP_W-1:0] LIM_NEG  = -LIM_POS;
    localparam logic signed [DISP_W-1:0] ONE      = DISP_W'(1);

    logic signed [DISP_W-1:0] disp_d;
    logic                     disp_err_d;

    // Next disparity with saturation at both ends; flag set on the updating edge
    always_comb begin
        disp_d     = disparity;
        disp_err_d = disp_err;
        if (pulse_en) begin
            if (pulse_neg) begin
                if (disparity != DISP_MIN) disp_d = disparity - ONE;
            end else begin
                if (disparity != DISP_MAX) disp_d = disparity + ONE;
            end
            if ((disp_d > LIM_POS) || (disp_d < LIM_NEG)) disp_err_d = 1'b1;
        end
    end

    // Disparity state register
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            disparity <= '0;
            disp_err  <= 1'b0;
        end else begin
            disparity <= disp_d;
            disp_err  <= disp_err_d;
        end
    end

endmodule

// File: rtl/hdb3_polar.sv
// HDB3 final stage: assigns bipolar line polarity and monitors V alternation and DC disparity.
module hdb3_polar
    import hdb3_polar_pkg::*;
#(
    parameter int unsigned DISP_W     = 6,
    parameter int unsigned DISP_LIMIT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [1:0]               data_in_b,
    output logic [1:0]               data_out_p,
    output logic                     hdb3_p,
    output logic                     hdb3_n,
    output logic                     out_valid,
    output logic                     v_err,
    output logic                     disp_err,
    output logic signed [DISP_W-1:0] disparity,
    output logic [CNT_W-1:0]         pulse_cnt
);

    pol_state_t       last_pol_q, last_pol_d;
    logic             last_v_neg_q, last_v_neg_d;
    logic             v_seen_q, v_seen_d;
    logic             v_err_d;
    logic [1:0]       pol_d;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_c;
    logic             pulse_neg_c;
    logic             v_neg_c;

    // Polarity alternation, V check and pulse counting
    always_comb begin
        last_pol_d   = last_pol_q;
        last_v_neg_d = last_v_neg_q;
        v_seen_d     = v_seen_q;
        v_err_d      = v_err;
        pol_d        = POL_ZERO;
        v_neg_c      = (last_pol_q == LAST_NEG);
        if (in_en) begin
            case (data_in_b)
                CODE_ONE, CODE_B: begin
                    if (last_pol_q == LAST_NEG) begin
                        pol_d      = POL_POS;
                        last_pol_d = LAST_POS;
                    end else begin
                        pol_d      = POL_NEG;
                        last_pol_d = LAST_NEG;
                    end
                end
                CODE_V: begin
                    pol_d = v_neg_c ? POL_NEG : POL_POS;
                    if (v_seen_q && (v_neg_c == last_v_neg_q)) v_err_d = 1'b1;
                    last_v_neg_d = v_neg_c;
                    v_seen_d     = 1'b1;
                end
                default: pol_d = POL_ZERO;
            endcase
        end
        pulse_c     = (pol_d != POL_ZERO);
        pulse_neg_c = (pol_d == POL_NEG);
        cnt_d       = pulse_cnt + CNT_W'(pulse_c);
    end

    // Output and state registers
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            data_out_p   <= POL_ZERO;
            out_valid    <= 1'b0;
            v_err        <= 1'b0;
            pulse_cnt    <= '0;
            last_pol_q   <= LAST_NEG;
            last_v_neg_q <= 1'b0;
            v_seen_q     <= 1'b0;
        end else begin
            data_out_p   <= pol_d;
            out_valid    <= in_en;
            v_err        <= v_err_d;
            pulse_cnt    <= cnt_d;
            last_pol_q   <= last_pol_d;
            last_v_neg_q <= last_v_neg_d;
            v_seen_q     <= v_seen_d;
        end
    end

    assign hdb3_p = data_out_p[0];
    assign hdb3_n = data_out_p[1];

    hdb3_polar_disparity #(
        .DISP_W     (DISP_W),
        .DISP_LIMIT (DISP_LIMIT)
    ) u_disparity (
        .clk       (clk),
        .rst       (rst),
        .pulse_en  (pulse_c),
        .pulse_neg (pulse_neg_c),
        .disparity (disparity),
        .disp_err  (disp_err)
    );

endmodule
